pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and reports its period, high time and duty cycle in whole percent. It is the decoding counterpart of `pwm_core`: the PWM generator drives the line, and this block recovers `period_count` and `duty_percent`. It sits on the input side of the PWM subsystem, and its results can be looped back against the generator's settings for self-test.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `TIMEOUT_CYCLES`, CLK_FREQ/10: number of cycles without an edge before the line is declared stuck. Must be less than 2^32-1.
- `FILTER_LEN`, 4: glitch-filter length in cycles. Used only when the filter is compiled in.
- `clk`  in  1: system clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `pwm_in`  in  1: asynchronous PWM input.
- `period_count`  out  32: cycles between the last two rising edges.
- `high_count`  out  32: cycles from a rising edge to the following falling edge.
- `duty_percent`  out  7: floor(high_count*100/period_count), range 0..100.
- `valid`  out  1: one-cycle pulse when new results are present on the outputs.
- `stuck`  out  1: level output; high while the line is timed out.
- `overrun`  out  1: one-cycle pulse when a measurement is dropped because the divider is busy.

## Operation
- Input path:
  - 2-flop synchronizer, then the optional filter, then an edge-detect register.
  - Only the resulting signal `pin` is used downstream.
- FSM states:
  - IDLE: wait for the first rising edge. No output is produced from this edge.
  - HIGH: counting while `pin` is high. A falling edge latches `high_cnt` and moves to LOW.
  - LOW: a rising edge closes the period and moves to HIGH.
  - A rising edge seen while in HIGH (no falling edge seen) is treated as closing the period, with high time equal to the full period.
- Counting:
  - `cyc_cnt` is cleared to 1 on each detected rising edge and increments every cycle.
  - The period equals the value of `cyc_cnt` on the cycle before the closing edge.
  - Counters saturate at 2^32-1.
- At a closing rising edge, if the divider is idle:
  - Capture the period and high time into the shadow registers.
  - Start the divider.
- At a closing rising edge, if the divider is busy:
  - The measurement is discarded and `overrun` pulses.
  - Counting still restarts from this edge.
- Divider:
  - Sequential restoring division of high*100 by period, one quotient bit per cycle, MSB first, 7 iterations.
  - The quotient fits in 7 bits because high ≤ period.
- Timeout:
  - If `cyc_cnt` reaches `TIMEOUT_CYCLES`, set `stuck`=1 and go to IDLE.
  - Pulse `valid` with `period_count`=0, `high_count`=0, and `duty_percent`=100 if `pin` is high or 0 if `pin` is low.
- `stuck` clears on the next detected rising edge.
- Reset values: all outputs 0, FSM in IDLE, divider idle.
- Reset asserted mid-measurement aborts everything. The first `valid` after reset needs two rising edges.

## Timing
- Detection latency: an edge sampled by the first synchronizer flop at clock edge N is detected at N+2, or N+2+FILTER_LEN with the filter compiled in.
- Result latency:
  - Shadow registers capture at the detection cycle D.
  - The divider runs D+1..D+7.
  - `period_count`, `high_count`, `duty_percent` and `valid` all update at D+8.
- Outputs hold their values between `valid` pulses.
- The minimum period measured without overrun is 8 cycles.
- A timeout pulse and a divider result never collide: a timeout cannot occur within 8 cycles of an edge.

## Configuration
- Feature macro: `PWM_CAPTURE_FILTER_EN`.
- Defined:
  - `pin` changes only after the synchronized input has held the new level for `FILTER_LEN` consecutive cycles.
  - Pulses shorter than this are rejected.
  - Both edges are delayed equally, so period and high time are unchanged.
- Undefined: filter bypassed; `FILTER_LEN` is ignored.

## Structure
- Shared package `pwm_pkg`:
  - `PWM_CNT_W`=32.
  - `PWM_DUTY_W`=7.
  - `PWM_DUTY_MAX`=100.
  - The capture FSM state enum.
- Sub-module `pwm_duty_div`:
  - Inputs: start, high, period.
  - Outputs: busy, done, quotient.
  - A 7-step restoring divider.

## Test plan
- Period 1000, high 300 → after the second rising edge: `valid` with `period_count`=1000, `high_count`=300, `duty_percent`=30; `stuck`=0.
- Period 500, high 250, then switched to period 2000, high 1500 → results 50, followed by 75 on the first full new period; no `overrun`.
- `TIMEOUT_CYCLES`=5000 and input held high for 6000 cycles → one `valid` with duty 100 and period 0; `stuck`=1 until the next rising edge. Repeat held low → duty 0.
- Period 6, high 3 → `overrun` pulses on alternate periods; accepted results show 6/3/50.
- 2-cycle glitch inside a 1000-cycle low phase:
  - With `PWM_CAPTURE_FILTER_EN` → results unchanged.
  - Without → spurious short periods are reported.
- `rstn` asserted mid-period → all outputs 0; no `valid` until two rising edges after release; then correct values.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared across the PWM subsystem.
//   PWM_CNT_W    - width of the period/high-time counters and results
//   PWM_DUTY_W   - width of the duty-cycle result (0..100 fits in 7 bits)
//   PWM_DUTY_MAX - full-scale duty value in percent
//   cap_state_e  - state encoding of the pwm_capture measurement FSM
package pwm_pkg;

  localparam int PWM_CNT_W    = 32;
  localparam int PWM_DUTY_W   = 7;
  localparam int PWM_DUTY_MAX = 100;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_HIGH,
    CAP_LOW
  } cap_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: sequential restoring divider computing
//   quotient = floor(high * 100 / period), one quotient bit per cycle, MSB first.
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   start          - load operands (ignored-free: caller only pulses when !busy)
//   high, period   - operands; high <= period guarantees a 7-bit quotient
//   busy           - high from the load cycle until the last step completes
//   done           - one-cycle pulse after the seventh step; quotient valid then
//   quotient       - result, held until the next start
module pwm_duty_div
  import pwm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [PWM_CNT_W-1:0]  high,
  input  logic [PWM_CNT_W-1:0]  period,
  output logic                  busy,
  output logic                  done,
  output logic [PWM_DUTY_W-1:0] quotient
);

  // high * 100 needs 32 + 7 bits; one spare bit keeps the shifted divisor in range.
  localparam int REM_W = PWM_CNT_W + 8;

  logic [REM_W-1:0]     rem_reg;
  logic [PWM_CNT_W-1:0] dvs_reg;
  logic [2:0]           step_reg;
  logic [REM_W-1:0]     dvs_shift;
  logic [REM_W:0]       trial;

  // Compare against period << step instead of shifting the remainder: the
  // dividend is known to be below period * 2^7, so 7 trial subtractions suffice.
  always_comb begin
    dvs_shift = REM_W'(dvs_reg) << step_reg;
    trial     = {1'b0, rem_reg} - {1'b0, dvs_shift};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_reg  <= '0;
      dvs_reg  <= '0;
      step_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_reg  <= REM_W'(high) * REM_W'(PWM_DUTY_MAX);
        dvs_reg  <= period;
        step_reg <= 3'd6;
        busy     <= 1'b1;
        quotient <= '0;
      end else if (busy) begin
        // A clear borrow bit means the trial subtraction fits: keep it, emit a 1.
        quotient <= {quotient[PWM_DUTY_W-2:0], ~trial[REM_W]};
        if (!trial[REM_W]) begin
          rem_reg <= trial[REM_W-1:0];
        end
        if (step_reg == 3'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          step_reg <= step_reg - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform (period, high time, duty %).
// Optional glitch filter compiled in with macro PWM_CAPTURE_FILTER_EN.
// Parameters:
//   CLK_FREQ       - clock frequency in Hz
//   TIMEOUT_CYCLES - cycles since the last rising edge before the line is stuck
//   FILTER_LEN     - glitch-filter length in cycles (filter builds only)
// Ports:
//   clk, rstn      - clock, asynchronous active-low reset
//   pwm_in         - asynchronous PWM input
//   period_count   - cycles between the last two rising edges
//   high_count     - cycles from rising edge to the following falling edge
//   duty_percent   - floor(high_count * 100 / period_count)
//   valid          - one-cycle pulse when new results are presented
//   stuck          - high while the line is timed out
//   overrun        - one-cycle pulse when a measurement is dropped (divider busy)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 10,
  parameter int FILTER_LEN     = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pwm_in,
  output logic [PWM_CNT_W-1:0]  period_count,
  output logic [PWM_CNT_W-1:0]  high_count,
  output logic [PWM_DUTY_W-1:0] duty_percent,
  output logic                  valid,
  output logic                  stuck,
  output logic                  overrun
);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("pwm_capture: FILTER_LEN must be at least 1");
  end

  logic [1:0]           sync_reg;
  logic                 pin;
  logic                 pin_prev_reg;
  logic                 rise;
  logic                 fall;
  cap_state_e           state_reg;
  logic [PWM_CNT_W-1:0] cyc_cnt_reg;
  logic [PWM_CNT_W-1:0] high_cnt_reg;
  logic [PWM_CNT_W-1:0] shadow_period_reg;
  logic [PWM_CNT_W-1:0] shadow_high_reg;
  logic [PWM_CNT_W-1:0] close_high;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [PWM_DUTY_W-1:0] div_quo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] filt_cnt_reg;
  logic              filt_reg;

  // The filtered level follows the synchronized input only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_cnt_reg <= '0;
      filt_reg     <= 1'b0;
    end else if (sync_reg[1] == filt_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FCNT_W'(FILTER_LEN - 1)) begin
      filt_reg     <= sync_reg[1];
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + FCNT_W'(1);
    end
  end

  assign pin = filt_reg;
`else
  assign pin = sync_reg[1];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pin_prev_reg <= 1'b0;
    end else begin
      pin_prev_reg <= pin;
    end
  end

  assign rise = pin & ~pin_prev_reg;
  assign fall = ~pin & pin_prev_reg;

  // A rise while still HIGH (no fall seen) counts the whole period as high time.
  assign close_high = (state_reg == CAP_HIGH) ? cyc_cnt_reg : high_cnt_reg;
  assign div_start  = rise && (state_reg != CAP_IDLE) && !div_busy;

  pwm_duty_div u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .high     (close_high),
    .period   (cyc_cnt_reg),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= CAP_IDLE;
      cyc_cnt_reg       <= '0;
      high_cnt_reg      <= '0;
      shadow_period_reg <= '0;
      shadow_high_reg   <= '0;
      period_count      <= '0;
      high_count        <= '0;
      duty_percent      <= '0;
      valid             <= 1'b0;
      stuck             <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;

      // Shadow registers may be reloaded on this same edge by a new capture;
      // the outputs take the values captured for the finishing division.
      if (div_done) begin
        period_count <= shadow_period_reg;
        high_count   <= shadow_high_reg;
        duty_percent <= div_quo;
        valid        <= 1'b1;
      end

      if (rise) begin
        cyc_cnt_reg <= PWM_CNT_W'(1);
        stuck       <= 1'b0;
        state_reg   <= CAP_HIGH;
        if (state_reg != CAP_IDLE) begin
          if (div_busy) begin
            overrun <= 1'b1;
          end else begin
            shadow_period_reg <= cyc_cnt_reg;
            shadow_high_reg   <= close_high;
          end
        end
      end else begin
        if (cyc_cnt_reg != '1) begin
          cyc_cnt_reg <= cyc_cnt_reg + PWM_CNT_W'(1);
        end
        if (state_reg == CAP_HIGH && fall) begin
          high_cnt_reg <= cyc_cnt_reg;
          state_reg    <= CAP_LOW;
        end
        // Timeout overrides a coincident fall; no division can be pending here.
        if (state_reg != CAP_IDLE && cyc_cnt_reg >= PWM_CNT_W'(TIMEOUT_CYCLES)) begin
          state_reg    <= CAP_IDLE;
          stuck        <= 1'b1;
          valid        <= 1'b1;
          period_count <= '0;
          high_count   <= '0;
          duty_percent <= pin ? PWM_DUTY_W'(PWM_DUTY_MAX) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture.
// A waveform-level model turns each driven input segment into expected
// results (period/high/duty, overrun, timeout, stuck) keyed by cycle; a
// monitor compares every output on every cycle, and literal checks pin the
// model at the end of each directed scenario.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int TMO  = 5000;
  localparam int FLEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FILT = FLEN;
`else
  localparam int FILT = 0;
`endif

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] h;
    logic [6:0]  d;
  } res_t;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  pwm_in = 1'b0;
  logic [PWM_CNT_W-1:0]  period_count;
  logic [PWM_CNT_W-1:0]  high_count;
  logic [PWM_DUTY_W-1:0] duty_percent;
  logic                  valid;
  logic                  stuck;
  logic                  overrun;

  pwm_capture #(
    .CLK_FREQ       (50_000_000),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pwm_in       (pwm_in),
    .period_count (period_count),
    .high_count   (high_count),
    .duty_percent (duty_percent),
    .valid        (valid),
    .stuck        (stuck),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_total = 0;

  // Model state
  res_t exp_valid[int];
  bit   exp_ovr[int];
  bit   exp_stuck_ev[int];
  bit   exp_stuck;
  res_t held;
  bit   m_armed;
  bit   m_level;
  int   m_rise;
  int   m_fall;
  int   m_last_acc;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycle, act, req);
    end
  endtask

  task automatic model_reset();
    exp_valid.delete();
    exp_ovr.delete();
    exp_stuck_ev.delete();
    exp_stuck  = 1'b0;
    held       = '0;
    m_armed    = 1'b0;
    m_level    = 1'b0;
    m_rise     = 0;
    m_fall     = -1;
    m_last_acc = -1000;
  endtask

  // Rising edge detected at cycle d: close the running period if one is open.
  task automatic on_rise(input int d);
    longint per, hi;
    res_t   r;
    if (m_armed) begin
      per = longint'(d - m_rise);
      hi  = (m_fall > m_rise) ? longint'(m_fall - m_rise) : per;
      if (d - m_last_acc < 8) begin
        exp_ovr[d] = 1'b1;
      end else begin
        r.p = 32'(per);
        r.h = 32'(hi);
        r.d = 7'((hi * 100) / per);
        exp_valid[d + 8] = r;
        m_last_acc = d;
      end
    end
    m_armed = 1'b1;
    m_rise  = d;
    exp_stuck_ev[d] = 1'b0;
  endtask

  // Drive one input segment at a negedge and hold it for 'hold' cycles.
  task automatic drive(input bit lvl, input int hold);
    int   n, d, t;
    res_t r;
    pwm_in = lvl;
    n = cycle + 1;          // first synchronizer flop samples at the next edge
    d = n + 2 + FILT;       // edge becomes visible to the measurement logic
    if (lvl != m_level && hold >= FILT) begin
      m_level = lvl;
      if (lvl) on_rise(d);
      else     m_fall = d;
    end
    // No further edge can be detected before d + hold.
    if (m_armed && m_rise + TMO < d + hold) begin
      t   = m_rise + TMO;
      r.p = '0;
      r.h = '0;
      r.d = m_level ? 7'd100 : 7'd0;
      exp_valid[t]    = r;
      exp_stuck_ev[t] = 1'b1;
      m_armed = 1'b0;
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input longint p, input longint h, input longint dty);
    check({tag, ".period"}, period_count, p);
    check({tag, ".high"}, high_count, h);
    check({tag, ".duty"}, duty_percent, dty);
  endtask

  // Per-cycle monitor
  initial begin
    bit   e_v, e_o;
    res_t r;
    forever begin
      @(negedge clk);
      #1;
      if (!rstn) begin
        check("rst.valid", valid, 0);
        check("rst.overrun", overrun, 0);
        check("rst.stuck", stuck, 0);
        check("rst.period", period_count, 0);
        check("rst.high", high_count, 0);
        check("rst.duty", duty_percent, 0);
      end else begin
        if (exp_stuck_ev.exists(cycle)) begin
          exp_stuck = exp_stuck_ev[cycle];
          exp_stuck_ev.delete(cycle);
        end
        e_v = exp_valid.exists(cycle);
        if (e_v) begin
          r    = exp_valid[cycle];
          held = r;
          exp_valid.delete(cycle);
        end
        e_o = exp_ovr.exists(cycle);
        if (e_o) exp_ovr.delete(cycle);
        if (overrun) ovr_total++;
        if (valid)
          $display("valid @%0d period=%0d high=%0d duty=%0d stuck=%0d",
                   cycle, period_count, high_count, duty_percent, stuck);
        check("valid", valid, e_v);
        check("overrun", overrun, e_o);
        check("stuck", stuck, exp_stuck);
        check("period_count", period_count, held.p);
        check("high_count", high_count, held.h);
        check("duty_percent", duty_percent, held.d);
      end
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int T5_P = 0,    T5_H = 0,    T5_D = 0,  T5_OVR = 0;
  localparam int T6_P = 2000, T6_H = 1000, T6_D = 50;
`else
  localparam int T5_P = 6,    T5_H = 3,    T5_D = 50, T5_OVR = 3;
  localparam int T6_P = 600,  T6_H = 2,    T6_D = 0;
`endif

  initial begin
    int ovr_base;
    model_reset();
    rstn   = 1'b0;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    drive(0, 20);

    // Period 1000, high 300
    for (int i = 0; i < 3; i++) begin
      drive(1, 300);
      drive(0, 700);
    end
    expect_out("p1000", 1000, 300, 30);
    check("p1000.stuck", stuck, 0);

    // 500/250 then 2000/1500
    for (int i = 0; i < 2; i++) begin
      drive(1, 250);
      drive(0, 250);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1500);
      drive(0, 500);
    end
    expect_out("p2000", 2000, 1500, 75);

    // Held high past the timeout
    drive(1, 6000);
    expect_out("tmo_high", 0, 0, 100);
    check("tmo_high.stuck", stuck, 1);

    // One rising edge clears stuck, then held low past the timeout
    drive(0, 200);
    drive(1, 200);
    check("rise.stuck_clear", stuck, 0);
    drive(0, 6000);
    expect_out("tmo_low", 0, 0, 0);
    check("tmo_low.stuck", stuck, 1);

    // Period 6, high 3: alternate periods overrun
    ovr_base = ovr_total;
    for (int i = 0; i < 7; i++) begin
      drive(1, 3);
      drive(0, 3);
    end
    expect_out("p6", T5_P, T5_H, T5_D);
    check("p6.overruns", ovr_total - ovr_base, T5_OVR);

    // 2-cycle glitch inside a 1000-cycle low phase
    for (int i = 0; i < 3; i++) begin
      drive(1, 1000);
      drive(0, 400);
      drive(1, 2);
      drive(0, 598);
    end
    drive(1, 1000);
    expect_out("glitch", T6_P, T6_H, T6_D);

    // Reset in the middle of a period
    drive(0, 300);
    rstn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    expect_out("in_rst", 0, 0, 0);
    repeat (7) @(negedge clk);
    rstn = 1'b1;
    drive(0, 50);
    drive(1, 300);
    drive(0, 700);
    check("post_rst.one_edge", period_count, 0);
    drive(1, 300);
    drive(0, 700);
    drive(1, 100);
    expect_out("post_rst", 1000, 300, 30);

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
